// File: rtl/operand_skid_buffer_17.sv
// rtl/operand_skid_buffer_17.sv - two-entry registered skid buffer between operand mux and SIMD execute
module operand_skid_buffer_17 #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] skid;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // out_data is the main register itself; all handshake outputs are registered per state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_data  <= '0;
      skid      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      count     <= 2'd0;
    end else if (flush) begin
      // data registers are left alone; only occupancy is discarded
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      count     <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            out_data  <= in_data;
            state     <= ONE;
            out_valid <= 1'b1;
            count     <= 2'd1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            out_data <= in_data;
          end else if (in_fire) begin
            skid     <= in_data;
            state    <= FULL;
            in_ready <= 1'b0;
            count    <= 2'd2;
          end else if (out_fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            count     <= 2'd0;
          end
        end
        FULL: begin
          if (out_fire) begin
            out_data <= skid;
            state    <= ONE;
            in_ready <= 1'b1;
            count    <= 2'd1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          count     <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/operand_skid_buffer_17.md
Name: operand_skid_buffer_17

Overview:
Registered 17-bit operand stage that consumes the output of the 17-bit operand select mux and feeds the SIMD execute stage.
- Breaks the combinational path from mux to execute with a valid/ready handshake.
- Two-entry skid buffer, so upstream sees a registered ready with no bubble at full throughput.
- Supports a pipeline flush issued on branch/exception.

Parameters:
WIDTH, 17, data width (mux output width; 16-bit SIMD word plus 1 tag/carry bit)

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  asynchronous, active-high reset
FLUSH  input  1  synchronous flush; discards all buffered entries
IN_VALID  input  1  upstream holds valid data on IN_DATA
IN_DATA  input  WIDTH  operand word from the select mux
IN_READY  output  1  registered; buffer can accept a word this cycle
OUT_VALID  output  1  OUT_DATA holds a valid word
OUT_DATA  output  WIDTH  operand word to execute stage
OUT_READY  input  1  execute stage accepts OUT_DATA this cycle
COUNT  output  2  number of held entries (0..2)

Behaviour:
- Handshakes:
  - in_fire = IN_VALID & IN_READY.
  - out_fire = OUT_VALID & OUT_READY.
  - A transfer occurs only on a rising edge where the fire term is 1.
- Storage: main register (drives OUT_DATA directly) and skid register; no combinational path from any input to any output.
- States:
  - EMPTY: COUNT=0, OUT_VALID=0, IN_READY=1.
  - ONE: COUNT=1, OUT_VALID=1, IN_READY=1.
  - FULL: COUNT=2, OUT_VALID=1, IN_READY=0.
- Transitions (no FLUSH):
  - EMPTY, in_fire: main<=IN_DATA, go to ONE. Latency is 1 cycle from IN accept to OUT_VALID.
  - ONE, in_fire & out_fire: main<=IN_DATA, stay in ONE (full throughput).
  - ONE, in_fire only: skid<=IN_DATA, go to FULL.
  - ONE, out_fire only: go to EMPTY.
  - FULL, out_fire: main<=skid, go to ONE.
  - FULL: in_fire is impossible because IN_READY=0. IN_VALID while FULL is ignored and upstream must hold its data.
  - Any state, no fire: hold all registers.
- Ordering: strict FIFO; output order equals accept order. No word is lost or duplicated.
- FLUSH:
  - On an edge with FLUSH=1, go to EMPTY, OUT_VALID=0, IN_READY=1, COUNT=0.
  - A same-cycle in_fire is discarded.
  - A same-cycle out_fire still counts as consumed by downstream.
  - FLUSH takes priority over all transitions.
- RESET:
  - Asserting RESET immediately (asynchronously) forces EMPTY, OUT_VALID=0, IN_READY=1, COUNT=0, OUT_DATA=0, skid=0.
  - This applies even mid-transfer or while FULL.
  - On the first edge after deassertion, normal operation resumes.
- OUT_DATA while OUT_VALID=0 holds its last value and is don't-care. FLUSH does not clear data registers.
- OUT_DATA must remain stable while OUT_VALID=1 and OUT_READY=0.

Test Plan:
1. Reset: assert RESET asynchronously between edges -> OUT_VALID=0, IN_READY=1, COUNT=0, OUT_DATA=17'h00000 before the next edge.
2. Streaming: OUT_READY=1, send 17'h00001..17'h00008 back-to-back -> outputs appear in order 1 cycle later, one per cycle, IN_READY stays 1, COUNT stays 1.
3. Backpressure:
   - OUT_READY=0, send 17'h1AAAA then 17'h05555 -> COUNT=2, IN_READY=0, OUT_DATA=17'h1AAAA stable.
   - Hold IN_VALID with 17'h0F0F0 for 3 cycles -> not accepted.
   - Raise OUT_READY -> outputs 17'h1AAAA, 17'h05555, 17'h0F0F0 in order.
4. Simultaneous in/out in ONE: main=17'h00010, in_fire with 17'h00020 and out_fire same edge -> COUNT=1, OUT_DATA=17'h00020.
5. Flush while FULL with concurrent in_fire attempt -> next cycle COUNT=0, OUT_VALID=0, IN_READY=1; the following accept of 17'h1FFFF appears alone on OUT_DATA.
6. Reset mid-operation in FULL -> immediate EMPTY. After release, 17'h00003 passes with 1-cycle latency and no stale skid data appears.
